// File: rtl/psoc_bus_pkg.sv
// Shared bus definitions for the psoc Wishbone fabric: arbiter state encoding,
// grant one-hot constants and the default slave timeout.
package psoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Counter width able to hold 0..t; at least one bit.
  function automatic int unsigned wd_width(input int unsigned t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/psoc_bus_watchdog.sv
// Bus watchdog: counts busy cycles since the last clear and flags the cycle in
// which the TIMEOUT-th busy cycle is reached. TIMEOUT=0 disables it.
module psoc_bus_watchdog
  import psoc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o,
  output logic expire_next_o
);

  localparam int unsigned CW = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic ARMED = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // The count holds the number of earlier busy cycles, so LAST marks the TIMEOUT-th one.
  assign expired_o     = ARMED && (cnt_q == LAST);
  assign expire_next_o = ARMED && (cnt_d == LAST);

endmodule

// File: rtl/psoc_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the psoc_audio slave,
// with a watchdog that answers a stalled transfer with an error.
module psoc_wb_arbiter
  import psoc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic                m0_stb_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic                m1_stb_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_stb_o,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o,
  output logic [7:0]          timeout_cnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 0: m0 served last, 1: m1 served last
  logic [1:0] grant_q, grant_d;
  logic       stb_q, stb_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       busy0, busy1, wd_expired, wd_expire_next, timeout_hit;

  assign busy0       = (state_q == ST_BUSY0);
  assign busy1       = (state_q == ST_BUSY1);
  assign timeout_hit = (busy0 || busy1) && wd_expired && !s_ack_i;

  psoc_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (state_q == ST_IDLE),
    .enable_i      (busy0 || busy1),
    .expired_o     (wd_expired),
    .expire_next_o (wd_expire_next)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_stb_i && m1_stb_i) state_d = last_q ? ST_BUSY0 : ST_BUSY1;
        else if (m0_stb_i)        state_d = ST_BUSY0;
        else if (m1_stb_i)        state_d = ST_BUSY1;
      end
      ST_BUSY0: begin
        if (s_ack_i || wd_expired || !m0_stb_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_BUSY1: begin
        if (s_ack_i || wd_expired || !m1_stb_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout_hit && (tcnt_q != 8'hFF)) tcnt_d = tcnt_q + 8'd1;
    unique case (state_d)
      ST_BUSY0: grant_d = GRANT_M0;
      ST_BUSY1: grant_d = GRANT_M1;
      default:  grant_d = GRANT_NONE;
    endcase
    // Strobe is withheld in advance for the cycle the watchdog will fire.
    stb_d = (state_d != ST_IDLE) && !wd_expire_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= GRANT_NONE;
      stb_q   <= 1'b0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      stb_q   <= stb_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign s_adr_o       = busy1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o       = busy1 ? m1_dat_i : m0_dat_i;
  assign s_we_o        = busy1 ? m1_we_i  : m0_we_i;
  assign s_sel_o       = busy1 ? m1_sel_i : m0_sel_i;
  assign s_stb_o       = stb_q;
  assign grant_o       = grant_q;
  assign timeout_cnt_o = tcnt_q;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = busy0 && s_ack_i;
  assign m1_ack_o = busy1 && s_ack_i;
  assign m0_err_o = busy0 && wd_expired && !s_ack_i;
  assign m1_err_o = busy1 && wd_expired && !s_ack_i;

endmodule
